// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and the gate network / host it drives.
// The sweeper takes the slave modport; the host/stimulus side takes master.
interface truth_table_sweeper_if;
    logic        START;
    logic        ABORT;
    logic        F;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic        E;
    logic        BUSY;
    logic        DONE;
    logic [31:0] TABLE;
    logic [5:0]  ERRCNT;
    logic        MATCH;

    modport master (
        output START, ABORT, F,
        input  A, B, C, D, E, BUSY, DONE, TABLE, ERRCNT, MATCH
    );

    modport slave (
        input  START, ABORT, F,
        output A, B, C, D, E, BUSY, DONE, TABLE, ERRCNT, MATCH
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks all 32 {A,B,C,D,E} vectors, captures F per vector into TABLE and counts golden-table mismatches.
// Compare logic (ERRCNT/MATCH) is only built when SWEEP_COMPARE_EN is defined; otherwise both read 0.
//
// state    | meaning
// S_IDLE   | waiting for START, A..E = 0
// S_APPLY  | holding vector index_q on A..E while the network settles
// S_SAMPLE | capturing F into TABLE[index_q]
// S_DONE   | sweep complete, results held until START or RST
module truth_table_sweeper #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [31:0] EXPECTED = 32'h00151515
) (
    input  logic                  CLK,
    input  logic                  RST,
    truth_table_sweeper_if.slave  sw
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // SETTLE of 0 still needs one APPLY cycle, so it shares the terminal count of SETTLE=1.
    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t      state_q,  state_d;
    logic [4:0]  index_q,  index_d;
    logic [3:0]  settle_q, settle_d;
    logic [31:0] table_q,  table_d;

    logic start_ok;
    logic busy;

    assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && sw.START;
    assign busy     = (state_q == S_APPLY) || (state_q == S_SAMPLE);

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        settle_d = settle_q;
        table_d  = table_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (sw.START) begin
                    state_d  = S_APPLY;
                    index_d  = 5'd0;
                    settle_d = 4'd0;
                    table_d  = 32'd0;
                end
            end

            S_APPLY: begin
                if (sw.ABORT) begin
                    state_d  = S_IDLE;
                    index_d  = 5'd0;
                    settle_d = 4'd0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = S_SAMPLE;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            S_SAMPLE: begin
                if (sw.ABORT) begin
                    state_d  = S_IDLE;
                    index_d  = 5'd0;
                    settle_d = 4'd0;
                end else begin
                    table_d[index_q] = sw.F;
                    if (index_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_APPLY;
                        index_d = index_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                index_d  = 5'd0;
                settle_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            index_q  <= 5'd0;
            settle_q <= 4'd0;
            table_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            settle_q <= settle_d;
            table_q  <= table_d;
        end
    end

`ifdef SWEEP_COMPARE_EN
    logic [5:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (start_ok) begin
            errcnt_d = 6'd0;
        end else if ((state_q == S_SAMPLE) && !sw.ABORT && (sw.F != EXPECTED[index_q])) begin
            errcnt_d = errcnt_q + 6'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            errcnt_q <= 6'd0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign sw.ERRCNT = errcnt_q;
    assign sw.MATCH  = (state_q == S_DONE) && (errcnt_q == 6'd0);
`else
    logic unused_cmp;
    assign unused_cmp = start_ok ^ (|EXPECTED);
    assign sw.ERRCNT  = 6'd0;
    assign sw.MATCH   = 1'b0;
`endif

    // Index parks at 31 in DONE, which gives the required all-ones vector there.
    assign {sw.A, sw.B, sw.C, sw.D, sw.E} = (state_q == S_IDLE) ? 5'd0 : index_q;

    assign sw.BUSY  = busy;
    assign sw.DONE  = (state_q == S_DONE);
    assign sw.TABLE = table_q;

endmodule
